// File: rtl/lrelu_config_writer.sv
// Steers LReLU config beats into the D register, BRAM_A or a BRAM_B bank.
// The external beats counter supplies the target and address fields; this block drives its enable.
module lrelu_config_writer #(
  parameter int unsigned MEMBERS     = 8,
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned KW_MAX      = 11,
  parameter int unsigned BITS_KH     = 4,
  parameter int unsigned BITS_CLR_I  = 3,
  parameter int unsigned BITS_W_ADDR = 4,
  parameter int unsigned D_WIDTH     = 16,
  localparam int unsigned B_BANKS    = (KW_MAX / 2 + 1) * (KW_MAX / 2 + 1),
  localparam int unsigned BITS_BANK  = $clog2(B_BANKS)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [MEMBERS*WORD_WIDTH-1:0] s_data,
  input  logic                          s_last,
  input  logic [1:0]                    w_sel,
  input  logic [BITS_CLR_I-1:0]         clr_i,
  input  logic [BITS_KH-1:0]            mtb,
  input  logic [BITS_W_ADDR-1:0]        w_addr,
  input  logic                          full,
  output logic                          cnt_en,
  output logic [D_WIDTH-1:0]            d_reg,
  output logic                          a_wen,
  output logic [BITS_W_ADDR-1:0]        a_waddr,
  output logic                          b_wen,
  output logic [BITS_BANK-1:0]          b_bank,
  output logic [BITS_W_ADDR-1:0]        b_waddr,
  output logic [MEMBERS*WORD_WIDTH-1:0] wdata,
  output logic                          done,
  output logic                          err_last
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e               state_q;
  logic                 fire;
  logic [BITS_BANK-1:0] clr_ext;
  logic [BITS_BANK-1:0] mtb_ext;
  logic [BITS_BANK-1:0] bank;

  assign s_ready = (state_q == StLoad);
  assign fire    = s_valid && s_ready;
  assign cnt_en  = fire;

  // Banks are laid out triangle-by-triangle: clr_i owns 2*clr_i+1 slots starting at clr_i^2.
  always_comb begin
    clr_ext = BITS_BANK'(clr_i);
    mtb_ext = BITS_BANK'(mtb);
    bank    = clr_ext * clr_ext + mtb_ext;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      d_reg    <= '0;
      a_wen    <= 1'b0;
      a_waddr  <= '0;
      b_wen    <= 1'b0;
      b_bank   <= '0;
      b_waddr  <= '0;
      wdata    <= '0;
      done     <= 1'b0;
      err_last <= 1'b0;
    end else begin
      a_wen <= 1'b0;
      b_wen <= 1'b0;
      done  <= 1'b0;

      unique case (state_q)
        StIdle: if (start) state_q <= StLoad;
        StLoad: begin
          if (fire && full) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (fire) begin
        if (s_last != full) err_last <= 1'b1;
        unique case (w_sel)
          2'd1: d_reg <= s_data[D_WIDTH-1:0];
          2'd2: begin
            a_wen   <= 1'b1;
            a_waddr <= w_addr;
            wdata   <= s_data;
          end
          2'd3: begin
            b_wen   <= 1'b1;
            b_bank  <= bank;
            b_waddr <= w_addr;
            wdata   <= s_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lrelu_config_writer.sv
// Directed bench for lrelu_config_writer; the bench plays the beats counter and
// checks BRAM writes through a scoreboard queue drained by a monitor.
module tb_lrelu_config_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [1:0]  w_sel = '0;
  logic [2:0]  clr_i = '0;
  logic [3:0]  mtb = '0;
  logic [3:0]  w_addr = '0;
  logic        full = 1'b0;
  logic        cnt_en;
  logic [15:0] d_reg;
  logic        a_wen;
  logic [3:0]  a_waddr;
  logic        b_wen;
  logic [5:0]  b_bank;
  logic [3:0]  b_waddr;
  logic [63:0] wdata;
  logic        done;
  logic        err_last;

  lrelu_config_writer dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .w_sel    (w_sel),
    .clr_i    (clr_i),
    .mtb      (mtb),
    .w_addr   (w_addr),
    .full     (full),
    .cnt_en   (cnt_en),
    .d_reg    (d_reg),
    .a_wen    (a_wen),
    .a_waddr  (a_waddr),
    .b_wen    (b_wen),
    .b_bank   (b_bank),
    .b_waddr  (b_waddr),
    .wdata    (wdata),
    .done     (done),
    .err_last (err_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_b;
    logic [5:0]  bank;
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  cnt_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (cnt_en) cnt_seen++;
        if (a_wen || b_wen) begin
          chk("wen_exclusive", 64'(a_wen && b_wen), 64'd0);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got a_wen=%0b b_wen=%0b expected no write",
                     a_wen, b_wen);
          end else begin
            e = exp_q.pop_front();
            chk("wr_target_b", 64'(b_wen), 64'(e.is_b));
            if (e.is_b) begin
              chk("b_bank", 64'(b_bank), 64'(e.bank));
              chk("b_waddr", 64'(b_waddr), 64'(e.addr));
              chk("b_bank_range", 64'(b_bank < 6'd36), 64'd1);
            end else begin
              chk("a_waddr", 64'(a_waddr), 64'(e.addr));
            end
            chk("wdata", wdata, e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] sel, input logic [2:0] clr, input logic [3:0] m,
                           input logic [3:0] addr, input logic f, input logic last,
                           input logic [63:0] data, input logic [5:0] ebank, input int bubbles);
    bit  fired;
    wr_t e;
    w_sel  = sel;
    clr_i  = clr;
    mtb    = m;
    w_addr = addr;
    full   = f;
    s_last = last;
    s_data = data;
    s_valid = 1'b0;
    repeat (bubbles) step();
    s_valid = 1'b1;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      @(negedge clk);
      if (s_ready) fired = 1'b1;
    end
    if (!fired) begin
      n_total++;
      $display("FAIL beat_accept: got s_ready=0 for 20 cycles expected 1");
    end else begin
      chk("cnt_en_on_fire", 64'(cnt_en), 64'd1);
      if (sel == 2'd2 || sel == 2'd3) begin
        e.is_b = (sel == 2'd3);
        e.bank = ebank;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
      end
    end
    step();
    s_valid = 1'b0;
  endtask

  // Called one step after the full beat fired: DONE cycle, then back to IDLE.
  task automatic expect_done(input bit poke_start);
    chk("done_pulse", 64'(done), 64'd1);
    chk("ready_in_done", 64'(s_ready), 64'd0);
    start = poke_start;
    step();
    start = 1'b0;
    chk("done_cleared", 64'(done), 64'd0);
    step();
    chk("idle_after_done", 64'(s_ready), 64'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_cnt_en", 64'(cnt_en), 64'd0);
    chk("rst_wen", 64'({a_wen, b_wen, done, err_last}), 64'd0);
    chk("rst_d_reg", 64'(d_reg), 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_bank", 64'(b_bank), 64'd0);
    step();
    rstn = 1'b1;
    step();

    // Minimal set: D, A, B with s_last on the third; start poked during DONE
    do_start();
    send_beat(2'd1, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'h1111_2222_3333_BEEF, 6'd0, 0);
    chk("d_reg_set1", 64'(d_reg), 64'h0000_0000_0000_BEEF);
    send_beat(2'd2, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'hA0A1_A2A3_A4A5_A6A7, 6'd0, 0);
    send_beat(2'd3, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1, 64'hB0B1_B2B3_B4B5_B6B7, 6'd0, 0);
    expect_done(1'b1);
    chk("err_last_clean", 64'(err_last), 64'd0);

    // kw2=1 set with bubbles: banks 0..3
    cnt_seen = 0;
    do_start();
    send_beat(2'd1, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'h0000_0000_0000_C0DE,
              6'd0, $urandom_range(0, 2));
    chk("d_reg_set2", 64'(d_reg), 64'h0000_0000_0000_C0DE);
    send_beat(2'd2, 3'd0, 4'd0, 4'd1, 1'b0, 1'b0, 64'h0101_0101_0101_0101,
              6'd0, $urandom_range(0, 2));
    send_beat(2'd3, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'h0202_0202_0202_0202,
              6'd0, $urandom_range(0, 2));
    send_beat(2'd3, 3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 64'h0303_0303_0303_0303,
              6'd1, $urandom_range(0, 2));
    send_beat(2'd3, 3'd1, 4'd1, 4'd0, 1'b0, 1'b0, 64'h0404_0404_0404_0404,
              6'd2, $urandom_range(0, 2));
    send_beat(2'd3, 3'd1, 4'd2, 4'd1, 1'b1, 1'b1, 64'h0505_0505_0505_0505,
              6'd3, $urandom_range(0, 2));
    expect_done(1'b0);
    chk("cnt_en_count", 64'(cnt_seen), 64'd6);

    // Largest bank for KW=11: clr_i=5, mtb=10 -> 25+10
    do_start();
    send_beat(2'd0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD, 6'd0, 1);
    send_beat(2'd3, 3'd5, 4'd10, 4'd7, 1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, 6'd35, 0);
    expect_done(1'b0);

    // s_last early on beat 2: sticky error, set still completes
    do_start();
    send_beat(2'd1, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'h0000_0000_0000_0042, 6'd0, 0);
    send_beat(2'd2, 3'd0, 4'd0, 4'd2, 1'b0, 1'b1, 64'h5555_6666_7777_8888, 6'd0, 0);
    chk("err_last_set", 64'(err_last), 64'd1);
    send_beat(2'd3, 3'd1, 4'd1, 4'd3, 1'b1, 1'b0, 64'h9999_AAAA_BBBB_CCCC, 6'd2, 0);
    expect_done(1'b0);
    chk("err_last_sticky", 64'(err_last), 64'd1);

    // Reset mid-LOAD; start pulsed while already loading is harmless
    do_start();
    send_beat(2'd1, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'h0000_0000_0000_1234, 6'd0, 0);
    do_start();
    send_beat(2'd2, 3'd0, 4'd0, 4'd5, 1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0, 6'd0, 0);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_flags", 64'({a_wen, b_wen, done, err_last, cnt_en}), 64'd0);
    chk("mid_rst_d_reg", 64'(d_reg), 64'd0);
    chk("mid_rst_wdata", wdata, 64'd0);
    chk("mid_rst_addr", 64'({a_waddr, b_waddr, b_bank}), 64'd0);
    step();
    rstn = 1'b1;
    step();
    do_start();
    send_beat(2'd1, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'h0000_0000_0000_5A5A, 6'd0, 0);
    chk("d_reg_reload", 64'(d_reg), 64'h0000_0000_0000_5A5A);
    send_beat(2'd3, 3'd2, 4'd3, 4'd9, 1'b1, 1'b1, 64'h7777_0000_7777_0000, 6'd7, 0);
    expect_done(1'b0);

    // s_valid in IDLE is ignored
    w_sel = 2'd2;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", 64'(s_ready), 64'd0);
      chk("idle_cnt_en", 64'(cnt_en), 64'd0);
    end
    step();
    s_valid = 1'b0;
    chk("d_reg_holds", 64'(d_reg), 64'h0000_0000_0000_5A5A);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
